uart_rx_os: RTL



---
 rtl/uart_rx_os.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// UART 8N1 receiver driven by an external oversampling tick (OVERSAMPLE ticks per bit).
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   boud_tick - one-clk oversampling enable pulse
//   rx        - asynchronous serial line, idle high
//   rx_data   - last correctly framed byte
//   rx_valid  - one-clk pulse when rx_data is updated
//   frame_err - one-clk pulse when the stop bit is sampled low
//   busy      - high whenever the receiver is not idle
module uart_rx_os #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT
    } state_t;

    logic                 rx_meta_q;
    logic                 rx_s_q;

    state_t               state_q,  state_d;
    logic [TW-1:0]        tick_q,   tick_d;
    logic [BW-1:0]        bit_q,    bit_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    logic                 valid_q,  valid_d;
    logic                 ferr_q,   ferr_d;

    // Two-flop synchroniser; resets to the idle (high) line level so
    // leaving reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic. Strobes default low so they clear on the next
    // clk even when no tick arrives.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (boud_tick) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!rx_s_q) begin
                        state_d = S_START;
                        tick_d  = '0;
                    end
                end

                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end else begin
                            // Line went back high before mid start bit:
                            // treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        // LSB arrives first, so shift in at the top.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        // Returning to IDLE mid stop bit lets a start
                        // bit that follows immediately be caught.
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_WAIT;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end

                S_WAIT: begin
                    // Hold off until the line is released so a break
                    // yields a single error and no phantom frames.
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        rx_data   = data_q;
        rx_valid  = valid_q;
        frame_err = ferr_q;
        busy      = (state_q != S_IDLE);
    end

endmodule
